// File: rtl/bloke2_sched.sv
// bloke2_sched: round scheduler for a BLAKE2s/BLAKE2b compression datapath.
// It sequences one compression per accepted message block:
//   working-vector load, R column/diagonal round pairs, chaining-value update.
// After the final block it pulses h_rdy for the output serializer.
// It also tracks hash-level state: init, wait-for-block and finalisation.
//
// Optional feature macro: BLOKE2_SCHED_OVERRUN_EN
//   Defined   -> a msg_strobe outside WAIT (without start) sets a sticky err.
//   Undefined -> err is tied low, and stray strobes are ignored with no
//                flop spent on tracking them.
//
// Every output is decoded from registered state only, so there is no
// combinational path from any input to any output.

module bloke2_sched #(
    parameter int W  = 32,                     // 32 = BLAKE2s, 64 = BLAKE2b
    parameter int R  = (W == 64) ? 12 : 10,    // rounds per compression
    parameter int RB = $clog2(R)               // derived; do not override
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          msg_strobe,
    input  logic          f_in,
    output logic          ready,
    output logic          h_init,
    output logic          v_load,
    output logic          f_out,
    output logic          g_en,
    output logic [RB-1:0] round,
    output logic          diag,
    output logic          h_update,
    output logic          h_rdy,
    output logic          err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        LOAD = 3'd2,
        COL  = 3'd3,
        DIAG = 3'd4,
        UPD  = 3'd5,
        DONE = 3'd6
    } state_t;

    localparam logic [RB-1:0] LAST_ROUND = RB'(R - 1);

    state_t        state, state_n;
    logic [RB-1:0] round_q, round_n;
    logic          fin_q, fin_n;
    logic          h_init_q;

    // State, round counter and the final-block flag latched at strobe time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            round_q <= '0;
            fin_q   <= 1'b0;
        end else begin
            state   <= state_n;
            round_q <= round_n;
            fin_q   <= fin_n;
        end
    end

    // h_init is a registered copy of start, so it appears exactly one cycle
    // after the start edge, alongside the first ready cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) h_init_q <= 1'b0;
        else        h_init_q <= start;
    end

`ifdef BLOKE2_SCHED_OVERRUN_EN
    logic err_q;

    // Sticky overrun flag: a block offered while not in WAIT is dropped and
    // flagged; start has priority and both clears the flag and eats the strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             err_q <= 1'b0;
        else if (start)                         err_q <= 1'b0;
        else if (msg_strobe && state != WAIT)   err_q <= 1'b1;
    end
`endif

    // Next-state logic; start overrides everything, including a mid-flight
    // compression, which is abandoned with no h_update/h_rdy
    always_comb begin
        state_n = state;
        round_n = round_q;
        fin_n   = fin_q;
        if (start) begin
            state_n = WAIT;
            round_n = '0;
        end else begin
            unique case (state)
                IDLE: state_n = IDLE;
                WAIT: begin
                    if (msg_strobe) begin
                        fin_n   = f_in;
                        state_n = LOAD;
                    end
                end
                LOAD: state_n = COL;
                COL:  state_n = DIAG;
                DIAG: begin
                    if (round_q == LAST_ROUND) begin
                        round_n = '0;
                        state_n = UPD;
                    end else begin
                        round_n = round_q + RB'(1);
                        state_n = COL;
                    end
                end
                UPD:  state_n = fin_q ? DONE : WAIT;
                DONE: state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // Output decode from registered state only
    always_comb begin
        ready    = 1'b0;
        h_init   = h_init_q;
        v_load   = 1'b0;
        f_out    = 1'b0;
        g_en     = 1'b0;
        round    = round_q;
        diag     = 1'b0;
        h_update = 1'b0;
        h_rdy    = 1'b0;
        err      = 1'b0;
`ifdef BLOKE2_SCHED_OVERRUN_EN
        err      = err_q;
`endif
        unique case (state)
            WAIT: ready = 1'b1;
            LOAD: begin
                v_load = 1'b1;
                f_out  = fin_q;
            end
            COL:  g_en = 1'b1;
            DIAG: begin
                g_en = 1'b1;
                diag = 1'b1;
            end
            UPD:  h_update = 1'b1;
            DONE: h_rdy = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/bloke2_sched.md
# bloke2_sched

Round scheduler for the BLAKE2 compression datapath. It sits between the message data manager and the G-function/state datapath. It accepts one 16-word message block per `msg_strobe`, then sequences the datapath through working-vector load, R column/diagonal round pairs and chaining-value update. After the final block it pulses `h_rdy` to the output serializer. It also owns hash-level state: init, wait-for-block, finalisation and overrun detection.

## Interface
- `W`, 32: word width in bits; 32 = BLAKE2s, 64 = BLAKE2b.
- `R`, 10: rounds per compression; 10 for W=32, 12 for W=64.
- `RB`, `$clog2(R)`: derived width of `round`. Not to be overridden.

- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  begin new hash; aborts any operation in progress.
- `msg_strobe`  in  1  message block complete and valid on datapath `m`/`t` inputs.
- `f_in`  in  1  final-block flag, sampled with `msg_strobe`.
- `ready`  out  1  scheduler can accept a `msg_strobe`; gates the data manager input.
- `h_init`  out  1  one-cycle pulse: datapath loads h from IV ^ parameter block.
- `v_load`  out  1  one-cycle pulse: datapath loads v from h, IV, t, f and latches m.
- `f_out`  out  1  final flag to the datapath; valid while `v_load` is high.
- `g_en`  out  1  G-step cycle active.
- `round`  out  RB  current round, 0..R-1, valid while `g_en` is high.
- `diag`  out  1  0 = column half-round, 1 = diagonal half-round.
- `h_update`  out  1  one-cycle pulse: h ^= v[0..7] ^ v[8..15].
- `h_rdy`  out  1  one-cycle pulse: h is the final digest.
- `err`  out  1  sticky overrun flag.

## Operation
- States:
  - `IDLE`: no hash active.
  - `WAIT`: hash active, waiting for a block.
  - `LOAD`, `COL`, `DIAG`, `UPD`: compression sequence.
  - `DONE`: one-cycle `h_rdy`.
- `ready` = (state == `WAIT`).
- `start` sampled in any state:
  - next state `WAIT`;
  - `h_init` = 1 in the following cycle;
  - `err` cleared;
  - `round` cleared to 0.
- `WAIT` with `msg_strobe`: latch `f_in` into the final register and go to `LOAD`.
- `LOAD`: `v_load` = 1 and `f_out` = latched final flag; next state `COL`.
- `COL`: `g_en` = 1, `diag` = 0; next state `DIAG`.
- `DIAG`: `g_en` = 1, `diag` = 1.
  - If `round` == R-1: clear `round` to 0, next state `UPD`.
  - Otherwise: increment `round`, next state `COL`.
- `UPD`: `h_update` = 1.
  - If the latched final flag is set: next state `DONE`.
  - Otherwise: next state `WAIT`.
- `DONE`: `h_rdy` = 1; next state `IDLE`. A further block requires a new `start`.
- Overrun:
  - `msg_strobe` while `ready` = 0 and `start` = 0 sets `err`.
  - The block is dropped and state is unaffected.
  - `err` holds until the next `start` or reset.
- `start` and `msg_strobe` in the same cycle: `start` wins, the strobe is dropped, `err` is not set.
- `start` mid-compression: the sequence is abandoned immediately with no `h_update` or `h_rdy`. The cycle after the start edge shows `h_init`, not a pending `g_en`.
- `round` counter: RB bits, saturating logic not required. The only wrap is the explicit R-1 → 0 clear in `DIAG`.

## Timing
- Reset values:
  - state `IDLE`, `round` = 0, latched final flag = 0;
  - `ready` = 0, `h_init` = 0, `v_load` = 0, `f_out` = 0;
  - `g_en` = 0, `diag` = 0, `h_update` = 0, `h_rdy` = 0, `err` = 0.
- All outputs are decoded from registered state only. No input-to-output combinational path.
- `start` sampled at edge k: `h_init` and `ready` are high in cycle k+1.
- `msg_strobe` sampled at edge k in `WAIT`:
  - `ready` low from cycle k+1;
  - `v_load` in cycle k+1;
  - `g_en` in cycles k+2 .. k+1+2R;
  - `h_update` in cycle k+2+2R;
  - non-final block: `ready` high again at k+3+2R;
  - final block: `h_rdy` at k+3+2R.
- R=10 figures: 23 cycles strobe-to-`h_rdy`; 22 cycles busy per non-final block.
- Throughput: one block per 2R+3 cycles (`WAIT` ≥ 1 cycle).

## Configuration
- `BLOKE2_SCHED_OVERRUN_EN`:
  - Defined: overrun detection as in Operation; `err` is sticky.
  - Undefined: `err` is tied to 0, and strobes outside `WAIT` are silently ignored with no register cost.

## Test plan
- Reset then `start` at edge 0 → `h_init` = 1 only in cycle 1; `ready` = 1 from cycle 1; all other outputs 0.
- Single final block (R=10), strobe with `f_in` = 1 at edge 5:
  - `v_load` and `f_out` in cycle 6;
  - `g_en` cycles 7–26, with `diag` alternating 0,1 and `round` 0,0,1,1,…,9,9;
  - `h_update` in cycle 27;
  - `h_rdy` in cycle 28;
  - `ready` stays 0 afterwards.
- Two blocks: non-final strobe, then strobe in the first `ready` cycle with `f_in` = 1 → exactly 2 `h_update` pulses and 1 `h_rdy`, 23 cycles after the second strobe.
- Strobe at cycle 10 of a compression (`BLOKE2_SCHED_OVERRUN_EN` defined) → `err` = 1 from the next cycle and the sequence is unchanged. Repeat with the macro undefined → `err` stays 0.
- `start` asserted during `g_en` cycle with `round` = 4 → next cycle `h_init` = 1 and `g_en` = 0; no `h_update` or `h_rdy`; `ready` = 1.
- `start` and `msg_strobe` in the same cycle from `WAIT` → `h_init` pulse, no `v_load`, `err` = 0; `rst_n` low mid-`COL` → all outputs 0 asynchronously.
